// File: rtl/jpeg_idct_pingpong_ram.sv
// Two-bank block store between IDCT passes: the writer fills one bank while the
// reader drains the other, with whole blocks handed over by done pulses.
module jpeg_idct_pingpong_ram #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 6,
    parameter int TRANSPOSE = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              wr_done_i,
    output logic              wr_ready_o,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic              rd_transpose_i,
    output logic [DATA_W-1:0] rd_data_o,
    input  logic              rd_done_i,
    output logic              rd_valid_o,
    output logic              err_o
);

    localparam int HALF  = ADDR_W / 2;
    localparam int DEPTH = 2 ** (ADDR_W + 1);

    logic [DATA_W-1:0] ram [0:DEPTH-1];

    logic       wr_bank_q;
    logic       rd_bank_q;
    logic [1:0] full_cnt_q;

    logic              wr_accept;
    logic              done_accept;
    logic              free_accept;
    logic [ADDR_W-1:0] eff_addr;

    assign wr_ready_o = (full_cnt_q != 2'd2);
    assign rd_valid_o = (full_cnt_q != 2'd0);

    assign wr_accept   = wr_i && wr_ready_o;
    assign done_accept = wr_done_i && wr_ready_o;
    assign free_accept = rd_done_i && rd_valid_o;

    // Transposed reads swap row and column halves of the address.
    generate
        if (TRANSPOSE != 0) begin : g_transpose
            assign eff_addr = rd_transpose_i
                ? {rd_addr_i[HALF-1:0], rd_addr_i[ADDR_W-1:HALF]}
                : rd_addr_i;
        end else begin : g_plain
            assign eff_addr = rd_addr_i;
        end
    endgenerate

    // Storage is not reset so it maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (wr_accept) begin
            ram[{wr_bank_q, wr_addr_i}] <= wr_data_i;
        end
    end

    // Non-blocking read against the same-edge write gives read-first behaviour.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_data_o <= '0;
        end else if (rd_en_i) begin
            rd_data_o <= ram[{rd_bank_q, eff_addr}];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            full_cnt_q <= 2'd0;
            err_o      <= 1'b0;
        end else begin
            if (done_accept) begin
                wr_bank_q <= ~wr_bank_q;
            end
            if (free_accept) begin
                rd_bank_q <= ~rd_bank_q;
            end
            case ({done_accept, free_accept})
                2'b10:   full_cnt_q <= full_cnt_q + 2'd1;
                2'b01:   full_cnt_q <= full_cnt_q - 2'd1;
                default: full_cnt_q <= full_cnt_q;
            endcase
            if ((wr_i && !wr_ready_o) || (wr_done_i && !wr_ready_o) ||
                (rd_done_i && !rd_valid_o)) begin
                err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_jpeg_idct_pingpong_ram.sv
// Directed bench for the ping-pong block store: handover, transpose, overflow,
// simultaneous handover, underflow and asynchronous reset.
module tb_jpeg_idct_pingpong_ram;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_done;
    logic              wr_ready;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_transpose;
    logic [DATA_W-1:0] rd_data;
    logic              rd_done;
    logic              rd_valid;
    logic              err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jpeg_idct_pingpong_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TRANSPOSE(1)) dut (
        .clk_i(clk), .rst_i(rst),
        .wr_i(wr), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .wr_done_i(wr_done), .wr_ready_o(wr_ready),
        .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_transpose_i(rd_transpose),
        .rd_data_o(rd_data), .rd_done_i(rd_done), .rd_valid_o(rd_valid),
        .err_o(err)
    );

    // Stimulus drivers: inputs change just after a falling edge and are
    // sampled back at the next falling edge, one rising edge later.
    task automatic write_block(input logic [DATA_W-1:0] base, input bit done_on_last);
        for (int a = 0; a < 64; a++) begin
            wr      = 1'b1;
            wr_addr = ADDR_W'(a);
            wr_data = base + DATA_W'(a);
            wr_done = done_on_last && (a == 63);
            @(negedge clk);
        end
        wr      = 1'b0;
        wr_done = 1'b0;
    endtask

    task automatic pulse_done(input bit w, input bit r);
        wr_done = w;
        rd_done = r;
        @(negedge clk);
        wr_done = 1'b0;
        rd_done = 1'b0;
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, input bit t);
        rd_en        = 1'b1;
        rd_addr      = a;
        rd_transpose = t;
        @(negedge clk);
        rd_en        = 1'b0;
        rd_transpose = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; wr = 0; wr_addr = '0; wr_data = '0; wr_done = 0;
        rd_en = 0; rd_addr = '0; rd_transpose = 0; rd_done = 0;
        #1;
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got %b want 1", wr_ready); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
        checks++; if (rd_data !== 16'h0) begin errors++; $display("FAIL reset_rd_data got %h want 0000", rd_data); end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_handover;
        write_block(16'h0000, 1'b0);
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL pre_done_rd_valid got %b want 0", rd_valid); end
        pulse_done(1'b1, 1'b0);
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL handover_rd_valid got %b want 1", rd_valid); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL handover_wr_ready got %b want 1", wr_ready); end
        do_read(6'd9, 1'b0);
        checks++; if (rd_data !== 16'd9) begin errors++; $display("FAIL read_addr9 got %0d want 9", rd_data); end
        // Data must hold while rd_en is low.
        @(negedge clk);
        checks++; if (rd_data !== 16'd9) begin errors++; $display("FAIL read_hold got %0d want 9", rd_data); end
        $display("test_handover done");
    endtask

    task automatic test_transpose;
        do_read(6'd9, 1'b1);
        checks++; if (rd_data !== 16'd9) begin errors++; $display("FAIL transpose_9 got %0d want 9", rd_data); end
        do_read(6'd10, 1'b1);
        checks++; if (rd_data !== 16'd17) begin errors++; $display("FAIL transpose_10 got %0d want 17", rd_data); end
        do_read(6'd10, 1'b0);
        checks++; if (rd_data !== 16'd10) begin errors++; $display("FAIL plain_10 got %0d want 10", rd_data); end
        $display("test_transpose done");
    endtask

    task automatic test_overflow;
        write_block(16'h0100, 1'b1);
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL full_wr_ready got %b want 0", wr_ready); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL full_err_early got %b want 0", err); end
        // Third write plus done while full: dropped, bank 0 (read side) untouched.
        wr = 1'b1; wr_addr = 6'd5; wr_data = 16'hdead; wr_done = 1'b1;
        @(negedge clk);
        wr = 1'b0; wr_done = 1'b0;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL overflow_err got %b want 1", err); end
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL overflow_wr_ready got %b want 0", wr_ready); end
        do_read(6'd5, 1'b0);
        checks++; if (rd_data !== 16'd5) begin errors++; $display("FAIL overflow_ram got %h want 0005", rd_data); end
        pulse_done(1'b0, 1'b1);
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL after_free_wr_ready got %b want 1", wr_ready); end
        do_read(6'd5, 1'b0);
        checks++; if (rd_data !== 16'h0105) begin errors++; $display("FAIL second_block got %h want 0105", rd_data); end
        $display("test_overflow done");
    endtask

    task automatic test_back_to_back;
        // Count is 1: writer on bank 0, reader on bank 1. Last write rides with wr_done.
        for (int a = 0; a < 63; a++) begin
            wr = 1'b1; wr_addr = ADDR_W'(a); wr_data = 16'h0200 + DATA_W'(a);
            @(negedge clk);
        end
        wr = 1'b1; wr_addr = 6'd63; wr_data = 16'h023f; wr_done = 1'b1; rd_done = 1'b1;
        // Read alongside rd_done must come from the old read bank.
        rd_en = 1'b1; rd_addr = 6'd4;
        @(negedge clk);
        wr = 1'b0; wr_done = 1'b0; rd_done = 1'b0; rd_en = 1'b0;
        checks++; if (rd_data !== 16'h0104) begin errors++; $display("FAIL read_with_done got %h want 0104", rd_data); end
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL swap_rd_valid got %b want 1", rd_valid); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL swap_wr_ready got %b want 1", wr_ready); end
        do_read(6'd3, 1'b0);
        checks++; if (rd_data !== 16'h0203) begin errors++; $display("FAIL swap_read3 got %h want 0203", rd_data); end
        do_read(6'd63, 1'b0);
        checks++; if (rd_data !== 16'h023f) begin errors++; $display("FAIL write_with_done got %h want 023f", rd_data); end
        $display("test_back_to_back done");
    endtask

    task automatic test_underflow;
        rst = 1'b1; #1; rst = 1'b0;
        @(negedge clk);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL underflow_pre_err got %b want 0", err); end
        pulse_done(1'b0, 1'b1);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL underflow_err got %b want 1", err); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL underflow_rd_valid got %b want 0", rd_valid); end
        // Pointers unchanged: next block goes to bank 0 and is read from bank 0.
        write_block(16'h0300, 1'b1);
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL underflow_valid_after got %b want 1", rd_valid); end
        do_read(6'd1, 1'b0);
        checks++; if (rd_data !== 16'h0301) begin errors++; $display("FAIL underflow_ptr got %h want 0301", rd_data); end
        $display("test_underflow done");
    endtask

    task automatic test_async_reset;
        write_block(16'h0400, 1'b1);
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL prereset_wr_ready got %b want 0", wr_ready); end
        wr = 1'b1; wr_addr = 6'd2; wr_data = 16'h0502;
        #2;
        rst = 1'b1;
        #1;
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL async_wr_ready got %b want 1", wr_ready); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL async_rd_valid got %b want 0", rd_valid); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL async_err got %b want 0", err); end
        checks++; if (rd_data !== 16'h0) begin errors++; $display("FAIL async_rd_data got %h want 0000", rd_data); end
        wr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        $display("test_async_reset done");
    endtask

    initial begin
        test_reset;
        test_handover;
        test_transpose;
        test_overflow;
        test_back_to_back;
        test_underflow;
        test_async_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
